// File: rtl/gray_sync_pkg.sv
// Shared defaults and gray/binary conversion helpers for gray_sync.
package gray_sync_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int MAXW            = 32;

  // Operands are zero-extended to MAXW, so any width up to MAXW converts correctly.
  function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b = '0;
    b[MAXW-1] = g[MAXW-1];
    for (int i = MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for gray-coded values.
module sync_chain #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] gray_o
);

  (* ASYNC_REG = "TRUE" *)
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign gray_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_sync.sv
// Event counter launched as registered gray code through a synchroniser,
// then decoded back to binary.
module gray_sync
  import gray_sync_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [WIDTH-1:0] out_val
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_d;
  logic [WIDTH-1:0] sync_gray;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;

  // Gray is encoded from the next count so gray_q always matches bin_q.
  always_comb begin
    bin_d  = enable ? bin_q + WIDTH'(1) : bin_q;
    gray_d = WIDTH'(bin2gray(MAXW'(bin_d)));
    out_d  = WIDTH'(gray2bin(MAXW'(sync_gray)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      out_q  <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      out_q  <= out_d;
    end
  end

  sync_chain #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .gray_i(gray_q),
    .gray_o(sync_gray)
  );

  assign out_val = out_q;

endmodule

// File: tb/tb_gray_sync.sv
// Directed bench for gray_sync: default 4-bit/2-stage instance and a
// 6-bit/3-stage instance.
module tb_gray_sync;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] out_val;
  logic       rst6;
  logic       en6;
  logic [5:0] out6;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit r;
    bit e;
    int x;
  } vec_t;

  vec_t vecs[$];

  gray_sync dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .out_val(out_val)
  );

  gray_sync #(
    .WIDTH      (6),
    .SYNC_STAGES(3)
  ) dut6 (
    .clk    (clk),
    .rst    (rst6),
    .enable (en6),
    .out_val(out6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int b2g(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit e, input int x);
    vec_t v;
    v.r = r;
    v.e = e;
    v.x = x;
    vecs.push_back(v);
  endtask

  initial begin
    int mdl;
    int prev_g;
    int pat[6];

    rst    = 1'b1;
    enable = 1'b0;
    rst6   = 1'b1;
    en6    = 1'b0;
    #1;
    check("reset_async_out", int'(out_val), 0);

    // reset then idle
    repeat (2) add(1, 0, 0);
    repeat (10) add(0, 0, 0);
    // 12 counted edges, then hold
    for (int j = 0; j < 12; j++) add(0, 1, (j < 3) ? 0 : j - 2);
    add(0, 0, 10);
    add(0, 0, 11);
    repeat (3) add(0, 0, 12);
    // restart from 0, 20 counted edges with wrap
    add(1, 0, 0);
    for (int j = 0; j < 20; j++) add(0, 1, (j < 3) ? 0 : (j - 2) % 16);
    add(0, 0, 2);
    add(0, 0, 3);
    repeat (3) add(0, 0, 4);
    // sparse enable pattern 1,0,1,1,0,1 from 4
    pat = '{1, 0, 1, 1, 0, 1};
    add(0, pat[0] != 0, 4);
    add(0, pat[1] != 0, 4);
    add(0, pat[2] != 0, 4);
    add(0, pat[3] != 0, 5);
    add(0, pat[4] != 0, 5);
    add(0, pat[5] != 0, 6);
    add(0, 0, 7);
    add(0, 0, 7);
    add(0, 0, 8);
    add(0, 0, 8);

    mdl    = 0;
    prev_g = 0;
    foreach (vecs[k]) begin
      @(negedge clk);
      rst    = vecs[k].r;
      enable = vecs[k].e;
      @(posedge clk);
      #1;
      if (vecs[k].r) mdl = 0;
      else if (vecs[k].e) mdl = (mdl + 1) % 16;
      check($sformatf("vec%0d_out", k), int'(out_val), vecs[k].x);
      check($sformatf("vec%0d_gray", k), int'(dut.gray_q), b2g(mdl));
      if (!vecs[k].r && vecs[k].e)
        check($sformatf("vec%0d_hamming", k),
              $countones(4'(prev_g) ^ dut.gray_q), 1);
      prev_g = int'(dut.gray_q);
    end

    // asynchronous reset mid-cycle at count 7
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_gray", int'(dut.gray_q), b2g(7));
    check("pre_rst_out", int'(out_val), 4);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out", int'(out_val), 0);
    check("mid_rst_gray", int'(dut.gray_q), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_e%0d", k), int'(out_val), (k == 4) ? 1 : 0);
    end
    check("post_rst_gray", int'(dut.gray_q), b2g(4));
    @(negedge clk);
    enable = 1'b0;

    // 6-bit, 3-stage instance: 70 counted edges
    @(negedge clk);
    rst6 = 1'b0;
    en6  = 1'b1;
    for (int j = 0; j < 70; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("w6_e%0d", j), int'(out6), (j < 4) ? 0 : (j - 3) % 64);
      @(negedge clk);
    end
    en6 = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("w6_hold%0d", j), int'(out6), (j < 4) ? (67 + j) % 64 : 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
